// File: rtl/uart_tx_buffer_pkg.sv
// rtl/uart_tx_buffer_pkg.sv - shared UART types and constants
// Buffer FSM states and character width used by the TX buffer slice.
package uartUtil;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic {
    BUF_IDLE   = 1'b0,
    BUF_ACTIVE = 1'b1
  } tx_buf_state_t;

endpackage

// File: rtl/uart_tx_buffer_if.sv
// rtl/uart_tx_buffer_if.sv - host write / transmitter handshake bundle
// master = host plus transmitter side, slave = the buffer itself.
interface uart_tx_buffer_if
  import uartUtil::*;
#(
  parameter int DEPTH = 16
);

  localparam int LW = $clog2(DEPTH) + 1;

  logic                      wr_valid;
  logic [UART_DATA_BITS-1:0] wr_data;
  logic                      wr_ready;
  logic                      send;
  logic [UART_DATA_BITS-1:0] byte_out;
  logic                      done;
  logic [LW-1:0]             level;
  logic                      busy;
  logic                      ovf_clr;
  logic                      overflow;

  modport master (
    output wr_valid, wr_data, done, ovf_clr,
    input  wr_ready, send, byte_out, level, busy, overflow
  );

  modport slave (
    input  wr_valid, wr_data, done, ovf_clr,
    output wr_ready, send, byte_out, level, busy, overflow
  );

endinterface

// File: rtl/uart_tx_buffer_fifo_mem.sv
// rtl/uart_tx_buffer_fifo_mem.sv - DEPTH x byte storage array
// Synchronous write port, asynchronous read port for the head byte.
module uart_fifo_mem
  import uartUtil::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [AW-1:0]             waddr,
  input  logic [UART_DATA_BITS-1:0] wdata,
  input  logic [AW-1:0]             raddr,
  output logic [UART_DATA_BITS-1:0] rdata
);

  logic [UART_DATA_BITS-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_buffer.sv
// rtl/uart_tx_buffer.sv - byte FIFO feeding the UART transmitter send/byte/done handshake
// Optional sticky overflow flag: UART_TX_BUF_OVERFLOW_EN.
module uart_tx_buffer
  import uartUtil::*;
#(
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_buffer_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [LW-1:0] level;
  logic [LW-1:0] level_next;
  logic          push;
  logic          pop;
  tx_buf_state_t state;
  tx_buf_state_t state_next;

  // Full is decided from registered level only, so a same-cycle done never opens a slot.
  assign bus.wr_ready = (level != LW'(DEPTH));
  assign push         = bus.wr_valid && bus.wr_ready;
  assign pop          = bus.done && (level != '0);

  always_comb begin
    level_next = level;
    if (push && !pop) begin
      level_next = level + LW'(1);
    end else if (pop && !push) begin
      level_next = level - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      level <= level_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BUF_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      BUF_IDLE: begin
        if (level_next != '0) begin
          state_next = BUF_ACTIVE;
        end
      end
      BUF_ACTIVE: begin
        if (pop && !push && (level == LW'(1))) begin
          state_next = BUF_IDLE;
        end
      end
      default: state_next = BUF_IDLE;
    endcase
  end

  assign bus.busy  = (state == BUF_ACTIVE);
  assign bus.level = level;

  // During the stop bit, keep send high only if another byte follows the head.
  assign bus.send = bus.done ? (level >= LW'(2)) : (level != '0);

  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (bus.wr_data),
    .raddr (rd_ptr),
    .rdata (bus.byte_out)
  );

`ifdef UART_TX_BUF_OVERFLOW_EN
  logic overflow_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else if (bus.wr_valid && !bus.wr_ready) begin
      overflow_q <= 1'b1;
    end else if (bus.ovf_clr) begin
      overflow_q <= 1'b0;
    end
  end

  assign bus.overflow = overflow_q;
`else
  logic ovf_clr_unused;
  assign ovf_clr_unused = bus.ovf_clr;
  assign bus.overflow   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_buffer.sv
// tb/tb_uart_tx_buffer.sv - queue-model bench for uart_tx_buffer
// Directed handshake scenarios followed by random traffic, DEPTH=4.
module tb_uart_tx_buffer;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_buffer_if #(.DEPTH(DEPTH)) bus ();

  uart_tx_buffer #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0] q[$];
  logic       ovf_m = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, compare against the queue model mid-cycle, then advance the model.
  task automatic step(input logic wv, input logic [7:0] wd, input logic dn,
                      input logic oc, input logic r);
    int  n;
    bit  do_push;
    bit  do_pop;
    bus.wr_valid = wv;
    bus.wr_data  = wd;
    bus.done     = dn;
    bus.ovf_clr  = oc;
    rst          = r;
    @(negedge clk);
    n = q.size();
    check("level",    32'(bus.level),    32'(n));
    check("wr_ready", 32'(bus.wr_ready), 32'(n < DEPTH));
    check("send",     32'(bus.send),     32'(dn ? (n >= 2) : (n != 0)));
    check("busy",     32'(bus.busy),     32'(n != 0));
    check("overflow", 32'(bus.overflow), 32'(ovf_m));
    if (n != 0) check("byte_out", 32'(bus.byte_out), 32'(q[0]));
    @(posedge clk);
    if (r) begin
      q.delete();
      ovf_m = 1'b0;
    end else begin
      do_push = wv && (n < DEPTH);
      do_pop  = dn && (n != 0);
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(wd);
`ifdef UART_TX_BUF_OVERFLOW_EN
      if (wv && (n >= DEPTH)) ovf_m = 1'b1;
      else if (oc) ovf_m = 1'b0;
`endif
    end
    #1;
  endtask

  initial begin
    bus.wr_valid = 1'b0;
    bus.wr_data  = 8'h00;
    bus.done     = 1'b0;
    bus.ovf_clr  = 1'b0;
    rst          = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // reset state and single-byte frame
    step(0, 8'h00, 0, 0, 0);
    step(1, 8'hA5, 0, 0, 0);
    check("a5_head", 32'(bus.byte_out), 32'h0000_00A5);
    step(0, 8'h00, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 0, 0, 0);

    // three chained frames: send stays high through each done while more remain
    step(1, 8'h11, 0, 0, 0);
    step(1, 8'h22, 0, 0, 0);
    step(1, 8'h33, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      repeat (3) step(0, 8'h00, 0, 0, 0);
      step(0, 8'h00, 1, 0, 0);
    end
    step(0, 8'h00, 0, 0, 0);

    // fill, overflow, clear
    for (int i = 1; i <= 5; i++) step(1, 8'(i), 0, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    step(1, 8'h06, 1, 0, 0);
    step(0, 8'h00, 0, 1, 0);
    step(0, 8'h00, 0, 0, 0);
    repeat (4) step(0, 8'h00, 1, 0, 0);

    // pop-with-push at level 1
    step(1, 8'h10, 0, 0, 0);
    step(1, 8'h7E, 1, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    check("7e_head", 32'(bus.byte_out), 32'h0000_007E);
    step(0, 8'h00, 1, 0, 0);

    // reset mid-frame with level 3, done held during reset
    for (int i = 0; i < 3; i++) step(1, 8'(8'hC0 + i), 0, 0, 0);
    step(0, 8'h00, 1, 0, 1);
    step(0, 8'h00, 0, 0, 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 9) < 6), 8'($urandom), ($urandom_range(0, 9) < 4),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 199) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
